// File: rtl/hist_pkg.sv
// Shared types and default sizes for the histogram frame sequencer.
package hist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } hist_state_e;

    localparam int HIST_DATA_W   = 16;
    localparam int HIST_NUM_BINS = 16;

endpackage

// File: rtl/hist_frame_ctrl.sv
// Frame sequencer: gates FRAME_LEN samples into the histogram core, then supervises
// the bin readout, forwarding beats downstream and flagging timeouts / bin-count mismatches.
module hist_frame_ctrl
    import hist_pkg::*;
#(
    parameter int DATA_W    = HIST_DATA_W,
    parameter int FRAME_LEN = 256,
    parameter int NUM_BINS  = HIST_NUM_BINS,
    parameter int TIMEOUT   = 1023,
    parameter int FCNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] hist_data,
    output logic              hist_write_en,
    input  logic              hist_ready,
    input  logic              hist_valid_out,
    input  logic              hist_last_bin,
    input  logic [7:0]        hist_bin_data,
    output logic [7:0]        m_data,
    output logic              m_valid,
    output logic              m_last,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              busy,
    output logic              err
);

    localparam int SCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int BCNT_W = $clog2(NUM_BINS + 1);
    localparam int ICNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(FRAME_LEN - 1);
    localparam logic [BCNT_W:0]   BINS_EXP    = (BCNT_W + 1)'(NUM_BINS);
    localparam logic [BCNT_W-1:0] BCNT_SAT    = BCNT_W'(NUM_BINS);
    localparam logic [ICNT_W-1:0] IDLE_MAX    = ICNT_W'(TIMEOUT);

    hist_state_e       r_state;
    hist_state_e       w_next;
    logic [SCNT_W-1:0] r_sample_cnt;
    logic [BCNT_W-1:0] r_bin_cnt;
    logic [ICNT_W-1:0] r_idle_cnt;
    logic [DATA_W-1:0] r_hist_data;
    logic              r_hist_write_en;
    logic [7:0]        r_m_data;
    logic              r_m_valid;
    logic              r_m_last;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              r_err;

    logic              w_accept;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_timeout;
    logic [BCNT_W:0]   w_bins_seen;
    logic              w_bin_err;

    assign s_ready     = (r_state == ACCUM) && hist_ready;
    assign w_accept    = s_ready && s_valid;
    assign w_beat      = (r_state == DRAIN) && hist_valid_out;
    assign w_last_beat = w_beat && hist_last_bin;
    // Timeout fires on an idle cycle once TIMEOUT idle cycles have already elapsed.
    assign w_timeout   = (r_state == DRAIN) && !hist_valid_out && (r_idle_cnt == IDLE_MAX);
    assign w_bins_seen = {1'b0, r_bin_cnt} + (BCNT_W + 1)'(1);
    assign w_bin_err   = w_last_beat && (w_bins_seen != BINS_EXP);

    assign hist_data     = r_hist_data;
    assign hist_write_en = r_hist_write_en;
    assign m_data        = r_m_data;
    assign m_valid       = r_m_valid;
    assign m_last        = r_m_last;
    assign frame_done    = (r_state == DONE);
    assign frame_cnt     = r_frame_cnt;
    assign busy          = (r_state != IDLE);
    assign err           = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = ACCUM;
            ACCUM:   if (w_accept && (r_sample_cnt == LAST_SAMPLE)) w_next = DRAIN;
            DRAIN:   if (w_last_beat || w_timeout) w_next = DONE;
            DONE:    w_next = cont ? ACCUM : IDLE;
            default: w_next = IDLE;
        endcase
        if (abort) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample_cnt    <= '0;
            r_bin_cnt       <= '0;
            r_idle_cnt      <= '0;
            r_hist_data     <= '0;
            r_hist_write_en <= 1'b0;
            r_m_data        <= '0;
            r_m_valid       <= 1'b0;
            r_m_last        <= 1'b0;
            r_frame_cnt     <= '0;
            r_err           <= 1'b0;
        end else begin
            // An abort suppresses everything that would otherwise surface next cycle.
            r_hist_write_en <= w_accept && !abort;
            if (w_accept && !abort) begin
                r_hist_data <= s_data;
            end
            r_m_valid <= w_beat && !abort;
            r_m_last  <= w_last_beat && !abort;
            if (w_beat && !abort) begin
                r_m_data <= hist_bin_data;
            end

            if (r_state != ACCUM) begin
                r_sample_cnt <= '0;
            end else if (w_accept) begin
                r_sample_cnt <= r_sample_cnt + SCNT_W'(1);
            end

            // Bin count saturates so surplus beats still register as a mismatch.
            if (r_state != DRAIN) begin
                r_bin_cnt  <= '0;
                r_idle_cnt <= '0;
            end else if (hist_valid_out) begin
                r_idle_cnt <= '0;
                if (r_bin_cnt != BCNT_SAT) begin
                    r_bin_cnt <= r_bin_cnt + BCNT_W'(1);
                end
            end else if (!w_timeout) begin
                r_idle_cnt <= r_idle_cnt + ICNT_W'(1);
            end

            if ((r_state == DRAIN) && (w_next == DONE)) begin
                r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            end

            if (!abort) begin
                if ((r_state == IDLE) && start) begin
                    r_err <= 1'b0;
                end else if (w_bin_err || w_timeout) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hist_frame_ctrl.sv
// Directed bench for hist_frame_ctrl: a per-cycle reference model plus literal frame-level checks.
module tb_hist_frame_ctrl;

    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 4;
    localparam int NUM_BINS  = 16;
    localparam int TIMEOUT   = 20;
    localparam int FCNT_W    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, cont, abort;
    logic [DATA_W-1:0] s_data;
    logic              s_valid, s_ready;
    logic [DATA_W-1:0] hist_data;
    logic              hist_write_en, hist_ready, hist_valid_out, hist_last_bin;
    logic [7:0]        hist_bin_data, m_data;
    logic              m_valid, m_last, frame_done, busy, err;
    logic [FCNT_W-1:0] frame_cnt;

    hist_frame_ctrl #(
        .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .NUM_BINS(NUM_BINS),
        .TIMEOUT(TIMEOUT), .FCNT_W(FCNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cont(cont), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .hist_data(hist_data), .hist_write_en(hist_write_en), .hist_ready(hist_ready),
        .hist_valid_out(hist_valid_out), .hist_last_bin(hist_last_bin), .hist_bin_data(hist_bin_data),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 collecting, 2 reading out, 3 frame end.
    int          md_st, md_acc, md_beats, md_idle;
    logic        md_we, md_mv, md_ml, md_err;
    logic [15:0] md_hd;
    logic [7:0]  md_md, md_fc;
    wire         mdl_s_ready = (md_st == 1) && hist_ready;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            md_st <= 0; md_acc <= 0; md_beats <= 0; md_idle <= 0;
            md_we <= 0; md_mv <= 0; md_ml <= 0; md_err <= 0;
            md_hd <= 0; md_md <= 0; md_fc <= 0;
        end else begin
            md_we <= mdl_s_ready && s_valid && !abort;
            if (mdl_s_ready && s_valid && !abort) md_hd <= s_data;
            md_mv <= (md_st == 2) && hist_valid_out && !abort;
            md_ml <= (md_st == 2) && hist_valid_out && hist_last_bin && !abort;
            if ((md_st == 2) && hist_valid_out && !abort) md_md <= hist_bin_data;
            if (abort) begin
                md_st <= 0;
            end else begin
                case (md_st)
                    0: if (start) begin md_st <= 1; md_acc <= 0; md_err <= 0; end
                    1: if (hist_ready && s_valid) begin
                        if (md_acc + 1 == FRAME_LEN) begin
                            md_st <= 2; md_beats <= 0; md_idle <= 0;
                        end else begin
                            md_acc <= md_acc + 1;
                        end
                    end
                    2: if (hist_valid_out) begin
                        md_beats <= md_beats + 1; md_idle <= 0;
                        if (hist_last_bin) begin
                            md_st <= 3; md_fc <= md_fc + 8'd1;
                            if (md_beats + 1 != NUM_BINS) md_err <= 1;
                        end
                    end else if (md_idle == TIMEOUT) begin
                        md_st <= 3; md_fc <= md_fc + 8'd1; md_err <= 1;
                    end else begin
                        md_idle <= md_idle + 1;
                    end
                    default: begin md_st <= cont ? 1 : 0; md_acc <= 0; end
                endcase
            end
        end
    end

    int          n_pass = 0, n_total = 0;
    int          wr_cnt = 0, mv_cnt = 0, ml_cnt = 0, ml_at = 0, fd_cnt = 0;
    logic [15:0] wr_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cmp_cycle();
        if (!reset) begin
            chk("s_ready", {31'd0, s_ready}, {31'd0, mdl_s_ready});
            chk("write_en", {31'd0, hist_write_en}, {31'd0, md_we});
            if (md_we) chk("hist_data", {16'd0, hist_data}, {16'd0, md_hd});
            chk("m_valid", {31'd0, m_valid}, {31'd0, md_mv});
            chk("m_last", {31'd0, m_last}, {31'd0, md_ml});
            if (md_mv) chk("m_data", {24'd0, m_data}, {24'd0, md_md});
            chk("frame_done", {31'd0, frame_done}, {31'd0, md_st == 3});
            chk("busy", {31'd0, busy}, {31'd0, md_st != 0});
            chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, md_fc});
            chk("err", {31'd0, err}, {31'd0, md_err});
        end
        if (hist_write_en) begin wr_cnt++; wr_log.push_back(hist_data); end
        if (m_valid) begin
            mv_cnt++;
            if (m_last) begin ml_cnt++; ml_at = mv_cnt; end
        end
        if (frame_done) fd_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_samples(input logic [15:0] base);
        for (int i = 0; i < FRAME_LEN; i++) begin
            hist_ready = 1; s_valid = 1; s_data = base + 16'(i);
            tick();
        end
        s_valid = 0;
    endtask

    task automatic do_beats(input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            hist_valid_out = 1; hist_bin_data = 8'h40 + 8'(i); hist_last_bin = (i == last_at);
            tick();
        end
        hist_valid_out = 0; hist_last_bin = 0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_frame_cnt"}, {24'd0, frame_cnt}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_write_en"}, {31'd0, hist_write_en}, 32'd0);
        chk({tag, "_hist_data"}, {16'd0, hist_data}, 32'd0);
        chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
        chk({tag, "_m_last"}, {31'd0, m_last}, 32'd0);
        chk({tag, "_m_data"}, {24'd0, m_data}, 32'd0);
        chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        int wr0, mv0, ml0, fd0, idx, k;
        bit seen;
        reset = 1; start = 0; cont = 0; abort = 0; s_data = 0; s_valid = 0;
        hist_ready = 1; hist_valid_out = 0; hist_last_bin = 0; hist_bin_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_checks("rst");
        @(posedge clk); #1;
        reset = 0;
        tick();

        // Frame 1: four back-to-back samples then a clean 16-bin readout.
        wr0 = wr_cnt; idx = wr_log.size();
        start = 1; tick(); start = 0;
        do_samples(16'd1);
        tick();
        chk("t1_writes", 32'(wr_cnt - wr0), 32'd4);
        for (int i = 0; i < 4; i++) chk("t1_wdata", {16'd0, wr_log[idx + i]}, 32'(i + 1));
        chk("t1_drain_s_ready", {31'd0, s_ready}, 32'd0);
        chk("t1_drain_busy", {31'd0, busy}, 32'd1);
        mv0 = mv_cnt; ml0 = ml_cnt; fd0 = fd_cnt;
        do_beats(16, 15);
        tick(); tick();
        chk("t3_m_valid_cnt", 32'(mv_cnt - mv0), 32'd16);
        chk("t3_m_last_cnt", 32'(ml_cnt - ml0), 32'd1);
        chk("t3_m_last_pos", 32'(ml_at - mv0), 32'd16);
        chk("t3_frame_done", 32'(fd_cnt - fd0), 32'd1);
        chk("t3_frame_cnt", {24'd0, frame_cnt}, 32'd1);
        chk("t3_err", {31'd0, err}, 32'd0);

        // Frame 2: hist_ready toggles while s_valid stays high.
        wr0 = wr_cnt; idx = wr_log.size();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 8; i++) begin
            hist_ready = (i % 2 == 0); s_valid = 1; s_data = 16'h100 + 16'(i);
            #1;
            chk("t2_s_ready", {31'd0, s_ready}, {31'd0, (i % 2 == 0)});
            tick();
        end
        s_valid = 0; hist_ready = 1;
        tick();
        chk("t2_writes", 32'(wr_cnt - wr0), 32'd4);
        for (int i = 0; i < 4; i++) chk("t2_wdata", {16'd0, wr_log[idx + i]}, 32'(16'h100 + 2 * i));

        // Short readout: last_bin on beat 15 flags err, sticky until next start.
        do_beats(15, 14);
        tick(); tick();
        chk("t4_err_set", {31'd0, err}, 32'd1);
        chk("t4_frame_cnt", {24'd0, frame_cnt}, 32'd2);
        mv0 = mv_cnt;
        hist_valid_out = 1; hist_bin_data = 8'hEE; tick();
        hist_valid_out = 0; tick();
        chk("t4_idle_beat_ignored", 32'(mv_cnt - mv0), 32'd0);
        chk("t4_err_sticky", {31'd0, err}, 32'd1);
        start = 1; tick(); start = 0;
        chk("t4_err_cleared", {31'd0, err}, 32'd0);

        // Frame 3: no readout beats, timeout closes the frame.
        do_samples(16'h200);
        fd0 = fd_cnt; k = 0; seen = 0;
        while (!seen && k < 200) begin
            tick(); k++;
            if (fd_cnt != fd0) seen = 1;
        end
        chk("t5_timeout_seen", {31'd0, seen}, 32'd1);
        chk("t5_timeout_latency", 32'(k), 32'(TIMEOUT + 2));
        chk("t5_err", {31'd0, err}, 32'd1);
        chk("t5_frame_cnt", {24'd0, frame_cnt}, 32'd3);
        tick();

        // Abort after two samples.
        wr0 = wr_cnt; fd0 = fd_cnt;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 2; i++) begin s_valid = 1; s_data = 16'h300 + 16'(i); tick(); end
        s_valid = 0; abort = 1; tick(); abort = 0;
        s_valid = 1; s_data = 16'h3FF;
        tick();
        chk("t6_abort_idle", {31'd0, busy}, 32'd0);
        tick(); tick();
        s_valid = 0;
        chk("t6_abort_writes", 32'(wr_cnt - wr0), 32'd2);
        chk("t6_abort_no_done", 32'(fd_cnt - fd0), 32'd0);
        chk("t6_abort_frame_cnt", {24'd0, frame_cnt}, 32'd3);
        chk("t6_abort_err", {31'd0, err}, 32'd0);

        // Asynchronous reset, then three frames chained with cont.
        reset = 1;
        @(negedge clk);
        reset_checks("rst2");
        @(posedge clk); #1;
        reset = 0;
        tick();
        fd0 = fd_cnt;
        cont = 1; start = 1; tick(); start = 0;
        for (int f = 0; f < 3; f++) begin
            do_samples(16'h400 + 16'(f * 16));
            do_beats(16, 15);
            if (f == 2) cont = 0;
            tick();
        end
        tick(); tick();
        chk("t6_chain_frame_cnt", {24'd0, frame_cnt}, 32'd3);
        chk("t6_chain_done", 32'(fd_cnt - fd0), 32'd3);
        chk("t6_chain_idle", {31'd0, busy}, 32'd0);
        chk("t6_chain_err", {31'd0, err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
